// File: rtl/path_input_pio.sv
`default_nettype none
// ============================================================================
// Module      : path_input_pio
// Description : Avalon-MM input PIO that synchronizes in_port, captures edges
//               into sticky write-1-to-clear bits and raises a masked level
//               IRQ. Define PATH_INPUT_PIO_SYNC_EN for a 2-flop synchronizer.
// Revision    : 1.0 - initial release
// ============================================================================
module path_input_pio #(
    parameter int          WIDTH       = 32,
    parameter int          EDGE_TYPE   = 0,
    parameter logic [31:0] RESET_VALUE = 32'h0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

`ifdef PATH_INPUT_PIO_SYNC_EN
    localparam int c_SYNC_STAGES = 2;
`else
    localparam int c_SYNC_STAGES = 1;
`endif
    // Edge detection stays off until the pipeline has refilled after reset,
    // so inputs already high at release never register as edges.
    localparam int c_PRIME_LEN = c_SYNC_STAGES + 1;

    logic [WIDTH-1:0]       data_q,     data_d;
    logic [WIDTH-1:0]       prev_q,     prev_d;
    logic [WIDTH-1:0]       capture_q,  capture_d;
    logic [WIDTH-1:0]       mask_q,     mask_d;
    logic [c_PRIME_LEN-1:0] prime_q,    prime_d;
    logic [31:0]            readdata_q, readdata_d;
    logic                   irq_q,      irq_d;

    logic                   wr_en;
    logic                   rd_en;
    logic                   primed;
    logic [WIDTH-1:0]       rise;
    logic [WIDTH-1:0]       fall;
    logic [WIDTH-1:0]       edge_sel;
    logic [WIDTH-1:0]       edge_det;
    logic [WIDTH-1:0]       clr;

`ifdef PATH_INPUT_PIO_SYNC_EN
    logic [WIDTH-1:0] meta_q, meta_d;

    always_comb begin
        meta_d = in_port;
        data_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= '0;
            data_q <= '0;
        end else begin
            meta_q <= meta_d;
            data_q <= data_d;
        end
    end
`else
    always_comb begin
        data_d = in_port;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end
`endif

    always_comb begin
        wr_en  = chipselect & ~write_n;
        rd_en  = chipselect & read;
        primed = prime_q[c_PRIME_LEN-1];

        rise = data_q & ~prev_q;
        fall = ~data_q & prev_q;
        case (EDGE_TYPE)
            1:       edge_sel = fall;
            2:       edge_sel = rise | fall;
            default: edge_sel = rise;
        endcase
        edge_det = primed ? edge_sel : '0;

        clr = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
        // Set dominates clear so an edge arriving during a clear is kept.
        capture_d = (capture_q & ~clr) | edge_det;
        mask_d    = (wr_en && address == 2'd2) ? writedata[WIDTH-1:0] : mask_q;

        prev_d  = data_q;
        prime_d = {prime_q[c_PRIME_LEN-2:0], 1'b1};
        irq_d   = |(capture_q & mask_q);

        readdata_d = '0;
        if (rd_en) begin
            case (address)
                2'd0:    readdata_d = 32'(data_q);
                2'd2:    readdata_d = 32'(mask_q);
                2'd3:    readdata_d = 32'(capture_q);
                default: readdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q     <= '0;
            capture_q  <= '0;
            mask_q     <= RESET_VALUE[WIDTH-1:0];
            prime_q    <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            prev_q     <= prev_d;
            capture_q  <= capture_d;
            mask_q     <= mask_d;
            prime_q    <= prime_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule
`default_nettype wire
